axi_prewrapper_regbank: RTL
===========================

# axi_prewrapper_regbank

Parametrised successor to the AXI prewrapper datapath: a word-addressed register bank between the AXI slave front end and the DUT/DFT test harness. It holds opcode/config/state/status words, packs an arbitrary-width DUT input vector from AXI writes, snapshots the DUT output vector on command, and buffers per-chain scan-out data as pointer-driven capture FIFOs with sticky overflow. Reads are registered with valid/error flags; unmapped accesses are detected rather than silently aliased.

## Interface
- P_SC_NBR, 16, number of scan chains (1..16)
- P_SC_DEPTH, 32, capture words per chain (1..63)
- DUT_IN_W, 256, DUT input vector width (1..256)
- DUT_OUT_W, 256, DUT output vector width (1..256)

- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-low
- axi_wr_en  in  1  write strobe, one word per cycle
- axi_wr_addr  in  32  word address of write
- axi_wr_msg  in  32  write data
- axi_rd_en  in  1  read request
- axi_rd_addr  in  32  word address of read
- axi_rd_msg  out  32  read data, registered
- axi_rd_valid  out  1  read data valid pulse
- axi_rd_err  out  1  read targeted unmapped address (with valid)
- dut_input_vec  out  DUT_IN_W  packed DUT input words
- dut_output_vec  in  DUT_OUT_W  DUT output
- dut_output_capture  in  1  snapshot dut_output_vec
- dft_output_data  in  32*P_SC_NBR  scan-out word per chain
- dft_output_valid  in  P_SC_NBR  per-chain push strobe
- ctrl_state  in  32  controller state, sampled every cycle
- ctrl_opcode  out  32  opcode register
- ctrl_opcode_wr  out  1  one-cycle pulse: opcode just written
- ctrl_config  out  32  config register

## Operation
- Address map (word): 0x00 opcode RW; 0x01 state RO; 0x02 config RW; 0x03 status RO; 0x04 clear WO; 0x10+k DUT-in word k RW, k < ceil(DUT_IN_W/32); 0x18+k DUT-out word k RO, k < ceil(DUT_OUT_W/32); 0x20+64*i+j chain i word j RO, i < P_SC_NBR, j < P_SC_DEPTH; 0x20+64*i+63 chain i count RO; 0xFF000000 loopback WO; 0xFF000001 loopback RO. Everything else unmapped.
- Writes: mapped RW/WO address updates target at the edge. Write to RO or unmapped address: no state change, sets status[16] (wr_err, sticky).
- dut_input_vec = low DUT_IN_W bits of DUT-in words, word 0 in bits [31:0]. DUT-in readback returns stored word, bits above DUT_IN_W zero.
- dut_output_capture high: shadow <= dut_output_vec (zero-extended); DUT-out reads return shadow.
- State register <= ctrl_state every cycle.
- Chain i: dft_output_valid[i] with count_i < P_SC_DEPTH writes word at index count_i, count_i += 1. With count_i == P_SC_DEPTH: word dropped, status[i] (overflow, sticky) set, count unchanged. Read of word j >= count_i returns 0. Count read returns count_i zero-extended.
- Status: [15:0] overflow per chain (unused bits 0), [16] wr_err, [17] rd_err sticky, rest 0.
- Clear write: bit i (i < P_SC_NBR) -> count_i = 0, overflow_i = 0; bit 16 clears wr_err; bit 17 clears rd_err. Clear beats a same-cycle push on that chain (push dropped, no overflow set).
- Loopback: RO address returns last value written to WO address.
- ctrl_opcode_wr: high the cycle after an opcode write, coincident with new ctrl_opcode.

## Timing
- Reset (reset==0 at edge): all registers, DUT-in words, shadow, counts, status, loopback = 0; axi_rd_msg=0, axi_rd_valid=0, axi_rd_err=0, ctrl_opcode_wr=0. Chain memory contents not reset (masked by count). Reset mid-capture abandons data.
- Read latency 1: axi_rd_en at edge N -> msg/valid at N+1, valid for one cycle; back-to-back reads every cycle. Unmapped read: msg=0, err=1, sets status[17].
- Same-cycle write and read to one address: read returns old value.
- Push at edge N visible to read issued at edge N+1; count increments at N.
- Outputs purely registered; no combinational path from AXI inputs to outputs.

## Test plan
- Reset -> ctrl_opcode=0, ctrl_config=0, dut_input_vec=0, rd_valid=0; read 0x03 returns 0.
- DUT_IN_W=40: write 0x10=0xDEADBEEF, 0x11=0xFFFFFFFF -> dut_input_vec=0xFF_DEADBEEF; write 0x12 -> wr_err, status=0x10000.
- Write 0x00=5 -> ctrl_opcode=5 and ctrl_opcode_wr pulse same cycle; read 0x01 returns ctrl_state one cycle later.
- P_SC_DEPTH=4: push 6 words 1..6 on chain 2 -> count=4, words 1..4 readable, status[2]=1; write 0x04=0x4 -> count 0, word 0 reads 0, status 0.
- Clear chain 0 with simultaneous push -> count 0, no overflow.
- Read 0x0000_0005 -> valid=1, err=1, msg=0, status[17]=1; loopback write 0x1234 then read 0xFF000001 -> 0x1234.

Source files
------------

// File: rtl/axi_prewrapper_regbank.sv
// Word-addressed register bank between the AXI slave front end and the DUT/DFT harness.
// Latency: writes land at the next edge; read data, valid and error are registered one cycle after axi_rd_en.
// Backpressure: none; one write and one read per cycle, a push into a full chain is dropped and flagged.
module axi_prewrapper_regbank #(
  parameter int P_SC_NBR   = 16,
  parameter int P_SC_DEPTH = 32,
  parameter int DUT_IN_W   = 256,
  parameter int DUT_OUT_W  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   axi_wr_en,
  input  logic [31:0]            axi_wr_addr,
  input  logic [31:0]            axi_wr_msg,
  input  logic                   axi_rd_en,
  input  logic [31:0]            axi_rd_addr,
  output logic [31:0]            axi_rd_msg,
  output logic                   axi_rd_valid,
  output logic                   axi_rd_err,
  output logic [DUT_IN_W-1:0]    dut_input_vec,
  input  logic [DUT_OUT_W-1:0]   dut_output_vec,
  input  logic                   dut_output_capture,
  input  logic [32*P_SC_NBR-1:0] dft_output_data,
  input  logic [P_SC_NBR-1:0]    dft_output_valid,
  input  logic [31:0]            ctrl_state,
  output logic [31:0]            ctrl_opcode,
  output logic                   ctrl_opcode_wr,
  output logic [31:0]            ctrl_config
);

  localparam int IN_WORDS  = (DUT_IN_W + 31) / 32;
  localparam int OUT_WORDS = (DUT_OUT_W + 31) / 32;
  localparam int IN_PAD    = IN_WORDS * 32;
  localparam int OUT_PAD   = OUT_WORDS * 32;
  localparam int CIW       = (P_SC_DEPTH > 1) ? $clog2(P_SC_DEPTH) : 1;
  localparam int NIW       = (P_SC_NBR > 1) ? $clog2(P_SC_NBR) : 1;
  localparam logic [31:0] CHAIN_END = 32'(32 + 64 * P_SC_NBR);
  localparam logic [5:0]  DEPTH6    = 6'(P_SC_DEPTH);
  // Ones over the real DUT input bits; padding bits of the last word read back as zero.
  localparam logic [IN_PAD-1:0] IN_MASK = {IN_PAD{1'b1}} >> (IN_PAD - DUT_IN_W);

  logic [31:0]         state_q;
  logic [31:0]         lb_q;
  logic [IN_PAD-1:0]   din_q;
  logic [OUT_PAD-1:0]  out_q;
  logic                wr_err_q;
  logic                rd_err_q;
  logic [P_SC_NBR-1:0] ovf_q;
  logic [5:0]          cnt_q [P_SC_NBR];
  logic [31:0]         mem   [P_SC_NBR][P_SC_DEPTH];

  logic wr_opc, wr_cfg, wr_clr, wr_din, wr_lb, wr_bad;
  logic [P_SC_NBR-1:0] clr_ch, push_ok, ovf_set;
  logic [31:0] rd_data;
  logic        rd_bad;
  logic [NIW-1:0] rd_i;
  logic [5:0]     rd_j;
  logic [31:0]    status;

  assign dut_input_vec = din_q[DUT_IN_W-1:0];
  assign status = {14'b0, rd_err_q, wr_err_q, 16'(ovf_q)};
  assign rd_i = NIW'((axi_rd_addr - 32'h20) >> 6);
  assign rd_j = 6'(axi_rd_addr - 32'h20);

  // Write decode: exactly one target strobe, or wr_bad for RO/unmapped addresses.
  always_comb begin
    wr_opc = 1'b0;
    wr_cfg = 1'b0;
    wr_clr = 1'b0;
    wr_din = 1'b0;
    wr_lb  = 1'b0;
    wr_bad = 1'b0;
    if (axi_wr_en) begin
      if (axi_wr_addr == 32'h0)
        wr_opc = 1'b1;
      else if (axi_wr_addr == 32'h2)
        wr_cfg = 1'b1;
      else if (axi_wr_addr == 32'h4)
        wr_clr = 1'b1;
      else if (axi_wr_addr[31:3] == 29'h2 && 32'(axi_wr_addr[2:0]) < 32'(IN_WORDS))
        wr_din = 1'b1;
      else if (axi_wr_addr == 32'hFF00_0000)
        wr_lb = 1'b1;
      else
        wr_bad = 1'b1;
    end
  end

  // Per-chain push qualification; a clear on the same chain wins and swallows the push.
  always_comb begin
    clr_ch  = '0;
    push_ok = '0;
    ovf_set = '0;
    for (int i = 0; i < P_SC_NBR; i++) begin
      clr_ch[i]  = wr_clr && axi_wr_msg[i];
      push_ok[i] = dft_output_valid[i] && !clr_ch[i] && (cnt_q[i] < DEPTH6);
      ovf_set[i] = dft_output_valid[i] && !clr_ch[i] && (cnt_q[i] == DEPTH6);
    end
  end

  // Read mux over the current (pre-edge) state, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    rd_bad  = 1'b0;
    if (axi_rd_addr == 32'h0)
      rd_data = ctrl_opcode;
    else if (axi_rd_addr == 32'h1)
      rd_data = state_q;
    else if (axi_rd_addr == 32'h2)
      rd_data = ctrl_config;
    else if (axi_rd_addr == 32'h3)
      rd_data = status;
    else if (axi_rd_addr[31:3] == 29'h2 && 32'(axi_rd_addr[2:0]) < 32'(IN_WORDS)) begin
      for (int k = 0; k < IN_WORDS; k++)
        if (axi_rd_addr[2:0] == 3'(k))
          rd_data = din_q[k*32 +: 32] & IN_MASK[k*32 +: 32];
    end
    else if (axi_rd_addr[31:3] == 29'h3 && 32'(axi_rd_addr[2:0]) < 32'(OUT_WORDS)) begin
      for (int k = 0; k < OUT_WORDS; k++)
        if (axi_rd_addr[2:0] == 3'(k))
          rd_data = out_q[k*32 +: 32];
    end
    else if (axi_rd_addr >= 32'h20 && axi_rd_addr < CHAIN_END) begin
      if (rd_j == 6'd63)
        rd_data = 32'(cnt_q[rd_i]);
      else if (rd_j < DEPTH6)
        rd_data = (rd_j < cnt_q[rd_i]) ? mem[rd_i][CIW'(rd_j)] : 32'h0;
      else
        rd_bad = 1'b1;
    end
    else if (axi_rd_addr == 32'hFF00_0001)
      rd_data = lb_q;
    else
      rd_bad = 1'b1;
  end

  // Registered read response: one-cycle valid pulse, data forced to zero on error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      axi_rd_msg   <= '0;
      axi_rd_valid <= 1'b0;
      axi_rd_err   <= 1'b0;
    end else begin
      axi_rd_valid <= axi_rd_en;
      axi_rd_err   <= axi_rd_en && rd_bad;
      axi_rd_msg   <= (axi_rd_en && !rd_bad) ? rd_data : 32'h0;
    end
  end

  // Control/config/loopback/DUT-vector registers and the sticky access-error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_opcode    <= '0;
      ctrl_opcode_wr <= 1'b0;
      ctrl_config    <= '0;
      state_q        <= '0;
      lb_q           <= '0;
      din_q          <= '0;
      out_q          <= '0;
      wr_err_q       <= 1'b0;
      rd_err_q       <= 1'b0;
    end else begin
      state_q        <= ctrl_state;
      ctrl_opcode_wr <= wr_opc;
      if (wr_opc) ctrl_opcode <= axi_wr_msg;
      if (wr_cfg) ctrl_config <= axi_wr_msg;
      if (wr_lb)  lb_q        <= axi_wr_msg;
      if (dut_output_capture) out_q <= OUT_PAD'(dut_output_vec);
      for (int k = 0; k < IN_WORDS; k++)
        if (wr_din && axi_wr_addr[2:0] == 3'(k))
          din_q[k*32 +: 32] <= axi_wr_msg;
      if (wr_bad)
        wr_err_q <= 1'b1;
      else if (wr_clr && axi_wr_msg[16])
        wr_err_q <= 1'b0;
      // A new bad read in the same cycle as a clear leaves the flag set.
      if (axi_rd_en && rd_bad)
        rd_err_q <= 1'b1;
      else if (wr_clr && axi_wr_msg[17])
        rd_err_q <= 1'b0;
    end
  end

  // Chain fill counts and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= '0;
      for (int i = 0; i < P_SC_NBR; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < P_SC_NBR; i++) begin
        if (clr_ch[i]) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (push_ok[i])
          cnt_q[i] <= cnt_q[i] + 6'd1;
        else if (ovf_set[i])
          ovf_q[i] <= 1'b1;
      end
    end
  end

  // Capture storage; not reset because reads beyond the count are masked to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < P_SC_NBR; i++)
      if (push_ok[i])
        mem[i][CIW'(cnt_q[i])] <= dft_output_data[i*32 +: 32];
  end

endmodule
